ps2_key_rx: RTL and testbench
=============================

PS2_KEY_RX -- requirements
Module: ps2_key_rx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, 8, event FIFO entries; power of 2, 2..64.
REQ-002 SHALL have parameter TIMEOUT_CYC, 50000, clk_in cycles without a key_clk falling edge before a partial frame is aborted.
REQ-003 SHALL have parameter FILTER_LEN, 4, clk_in cycles key_clk must be stable before a level change is accepted; 1..15.
REQ-004 clk_in  input  1  system clock.
REQ-005 rst_n_in  input  1  asynchronous, active-low reset.
REQ-006 key_clk  input  1  PS/2 clock from keyboard, asynchronous.
REQ-007 key_data  input  1  PS/2 data from keyboard, asynchronous.
REQ-008 ev_valid  output  1  event FIFO non-empty.
REQ-009 ev_ready  input  1  consumer accepts head event.
REQ-010 ev_code  output  8  head event scan code.
REQ-011 ev_ext  output  1  head event was E0-prefixed.
REQ-012 ev_brk  output  1  head event is a release (F0-prefixed).
REQ-013 ev_ascii  output  8  head event ASCII: "A".."Z" for non-extended letter codes, else 8'h00.
REQ-014 held  output  1  a key is currently held.
REQ-015 held_code  output  9  {ext, code} of most recently pressed key still held.
REQ-016 err_parity, err_frame, err_timeout, err_overflow  output  1 each  single-cycle error pulses.

Function
REQ-017 key_clk and key_data SHALL each pass a 2-flop synchroniser; key_clk then passes the FILTER_LEN stability filter; falling edge = filtered previous 1, current 0.
REQ-018 Each falling edge SHALL sample synchronised key_data; frame = start(0), 8 data LSB first, odd parity, stop(1); bit counter 0..10.
REQ-019 Start bit 1 SHALL be ignored, counter stays 0 (resynchronise on next edge).
REQ-020 On the 11th edge: parity mismatch -> err_parity pulse, byte dropped; stop 0 -> err_frame pulse, byte dropped; both wrong -> err_parity only.
REQ-021 Idle-watchdog counter SHALL run while counter != 0, clear on every falling edge; at TIMEOUT_CYC -> counter to 0, err_timeout pulse, partial byte discarded.
REQ-022 Decoder FSM states IDLE, EXT, BRK, EXT_BRK; good byte E0: IDLE->EXT; F0: IDLE->BRK, EXT->EXT_BRK; other byte: emit event {ext per state, brk per state, code}, return to IDLE.
REQ-023 E0 in EXT/BRK/EXT_BRK, or F0 in BRK/EXT_BRK, SHALL return to IDLE without event, err_frame pulse.
REQ-024 Timeout SHALL also return decoder to IDLE.
REQ-025 Event SHALL be written to FIFO the cycle after the completing edge is detected; ev_valid high the following cycle (latency 2 clk_in from edge detection).
REQ-026 Pop occurs on ev_valid & ev_ready; ev_* outputs show head entry, stable while ev_valid & !ev_ready.
REQ-027 Push when full without simultaneous pop: new event dropped, err_overflow pulse, FIFO contents unchanged; push and pop in the same cycle when full SHALL succeed.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH; occupancy count width clog2(FIFO_DEPTH)+1.
REQ-029 held tracking: make event -> held=1, held_code={ext,code}; break event matching held_code -> held=0; non-matching break -> no change; updated at the FIFO-write cycle irrespective of overflow.

Reset
REQ-030 Reset SHALL asynchronously clear: synchroniser/filter flops to 1, bit counter, watchdog, FSM to IDLE, FIFO pointers and count, held=0, held_code=0, all error pulses 0.
REQ-031 After reset ev_valid=0; ev_code, ev_ext, ev_brk, ev_ascii = 0.
REQ-032 Reset mid-frame SHALL discard the partial byte; next frame decodes normally.

Structure
REQ-033 Package ps2_pkg SHALL hold: event struct {ext, brk, code}, constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, decoder state enum, scan-code-to-ASCII function.
REQ-034 FIFO SHALL be a sub-module ps2_event_fifo parametrised by FIFO_DEPTH and entry width.

Verification
REQ-035 Frame 0x1C, parity 0, stop 1, ev_ready=1 -> one event code=1C ext=0 brk=0 ascii=8'h41, held=1, held_code=9'h01C.
REQ-036 Bytes F0,1C -> event code=1C brk=1 ascii=8'h41, held=0; bytes E0,F0,75 -> event code=75 ext=1 brk=1 ascii=00.
REQ-037 Frame 0x1C with parity 1 -> err_parity one cycle, no event, decoder stays IDLE.
REQ-038 Four bits then key_clk idle TIMEOUT_CYC cycles -> err_timeout one cycle; next complete 0x1D frame -> event code=1D ascii=8'h57.
REQ-039 FIFO_DEPTH=4, ev_ready=0, five make codes 15,1D,24,2D,2C -> fifth drops, err_overflow once; raising ev_ready pops 15,1D,24,2D in order, then ev_valid=0.
REQ-040 Glitch on key_clk shorter than FILTER_LEN cycles mid-frame -> no bit sampled, frame decodes correctly.

Source files
------------

// File: rtl/ps2_key_rx_pkg.sv
// Shared types and helpers for the PS/2 keyboard receiver: event record,
// prefix byte constants, decoder state encoding and scan-code to ASCII map.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_event_t;

  localparam int PS2_EVENT_W = $bits(ps2_event_t);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } dec_state_t;

  // Set-2 letter scan codes map to upper-case ASCII; extended codes never do.
  function automatic logic [7:0] scan_to_ascii(input logic ext, input logic [7:0] code);
    logic [7:0] a;
    a = 8'h00;
    if (!ext) begin
      case (code)
        8'h1C: a = 8'h41; 8'h32: a = 8'h42; 8'h21: a = 8'h43; 8'h23: a = 8'h44;
        8'h24: a = 8'h45; 8'h2B: a = 8'h46; 8'h34: a = 8'h47; 8'h33: a = 8'h48;
        8'h43: a = 8'h49; 8'h3B: a = 8'h4A; 8'h42: a = 8'h4B; 8'h4B: a = 8'h4C;
        8'h3A: a = 8'h4D; 8'h31: a = 8'h4E; 8'h44: a = 8'h4F; 8'h4D: a = 8'h50;
        8'h15: a = 8'h51; 8'h2D: a = 8'h52; 8'h1B: a = 8'h53; 8'h2C: a = 8'h54;
        8'h3C: a = 8'h55; 8'h2A: a = 8'h56; 8'h1D: a = 8'h57; 8'h22: a = 8'h58;
        8'h35: a = 8'h59; 8'h1A: a = 8'h5A;
        default: a = 8'h00;
      endcase
    end
    return a;
  endfunction

endpackage

// File: rtl/ps2_key_rx_if.sv
// Key-event stream: valid/ready handshake carrying the decoded head event.
interface ps2_key_rx_if;
  logic       ev_valid;
  logic       ev_ready;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_brk;
  logic [7:0] ev_ascii;

  modport master (output ev_valid, ev_code, ev_ext, ev_brk, ev_ascii, input ev_ready);
  modport slave  (input ev_valid, ev_code, ev_ext, ev_brk, ev_ascii, output ev_ready);
endinterface

// File: rtl/ps2_key_rx_fifo.sv
// Event FIFO: power-of-two ring buffer with occupancy counter. A push into a
// full FIFO is dropped (overflow pulse) unless a pop happens the same cycle.
module ps2_event_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             not_empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointer/occupancy bookkeeping and the overflow pulse.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push & full & ~do_pop;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array; when full with a simultaneous pop, the slot being read this
  // cycle is the one overwritten at the edge, which is safe.
  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head      = empty ? '0 : mem[rd_ptr];
  assign not_empty = ~empty;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronises and de-glitches the keyboard lines,
// deframes 11-bit frames, decodes E0/F0 prefixes into key events, queues them
// in a FIFO and tracks the most recently pressed, still-held key.
module ps2_key_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FILTER_LEN  = 4
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            key_clk,
  input  logic            key_data,
  ps2_key_rx_if.master    ev,
  output logic            held,
  output logic [8:0]      held_code,
  output logic            err_parity,
  output logic            err_frame,
  output logic            err_timeout,
  output logic            err_overflow
);

  localparam int             WD_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]     FLT_LAST = 4'(FILTER_LEN - 1);

  logic clk_sync_p0, clk_sync_p1;
  logic data_sync_p0, data_sync_p1;
  logic clk_filt, clk_filt_prev;
  logic [3:0] flt_cnt;
  logic fall;

  // Two-flop synchronisers for both keyboard lines; idle level is high.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      clk_sync_p0  <= 1'b1;
      clk_sync_p1  <= 1'b1;
      data_sync_p0 <= 1'b1;
      data_sync_p1 <= 1'b1;
    end else begin
      clk_sync_p0  <= key_clk;
      clk_sync_p1  <= clk_sync_p0;
      data_sync_p0 <= key_data;
      data_sync_p1 <= data_sync_p0;
    end
  end

  // Stability filter: a new key_clk level is accepted only after it has been
  // seen on FILTER_LEN consecutive cycles, so short glitches never reach the deframer.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      clk_filt      <= 1'b1;
      clk_filt_prev <= 1'b1;
      flt_cnt       <= '0;
    end else begin
      clk_filt_prev <= clk_filt;
      if (clk_sync_p1 == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        clk_filt <= clk_sync_p1;
        flt_cnt  <= '0;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign fall = clk_filt_prev & ~clk_filt;

  // ---- deframer stage ----
  logic [3:0]      bit_cnt;
  logic [7:0]      rx_byte;
  logic            par_bit;
  logic [WD_W-1:0] wd_cnt;
  logic            frame_end;
  logic            parity_ok;
  logic            byte_ok;
  logic            timeout;
  logic            rx_err_frame;

  assign frame_end = fall && (bit_cnt == 4'd10);
  assign parity_ok = ^{rx_byte, par_bit};
  assign byte_ok   = frame_end & parity_ok & data_sync_p1;
  assign timeout   = !fall && (bit_cnt != 4'd0) && (wd_cnt == WD_LAST);

  // Bit counter, idle watchdog and deframing error pulses.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bit_cnt      <= '0;
      wd_cnt       <= '0;
      err_parity   <= 1'b0;
      rx_err_frame <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      err_parity   <= frame_end & ~parity_ok;
      rx_err_frame <= frame_end & parity_ok & ~data_sync_p1;
      err_timeout  <= timeout;
      if (fall) begin
        wd_cnt <= '0;
        if (bit_cnt == 4'd0) begin
          if (!data_sync_p1) bit_cnt <= 4'd1;
        end else if (bit_cnt == 4'd10) begin
          bit_cnt <= 4'd0;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else if (timeout) begin
        bit_cnt <= '0;
        wd_cnt  <= '0;
      end else if (bit_cnt != 4'd0) begin
        wd_cnt <= wd_cnt + 1'b1;
      end else begin
        wd_cnt <= '0;
      end
    end
  end

  // Data bits arrive LSB first; the parity bit is captured separately.
  always_ff @(posedge clk_in) begin
    if (fall && (bit_cnt >= 4'd1) && (bit_cnt <= 4'd8)) rx_byte <= {data_sync_p1, rx_byte[7:1]};
    if (fall && (bit_cnt == 4'd9)) par_bit <= data_sync_p1;
  end

  // ---- decoder stage ----
  dec_state_t state;
  ps2_event_t ev_p1;
  logic       vld_p1;
  logic       dec_err_frame;

  // Prefix decoder: E0/F0 set pending flags, any other byte completes an event.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state         <= IDLE;
      ev_p1         <= '0;
      vld_p1        <= 1'b0;
      dec_err_frame <= 1'b0;
    end else begin
      vld_p1        <= 1'b0;
      dec_err_frame <= 1'b0;
      if (timeout) begin
        state <= IDLE;
      end else if (byte_ok) begin
        case (state)
          IDLE: begin
            if (rx_byte == PS2_EXT)      state <= EXT;
            else if (rx_byte == PS2_BRK) state <= BRK;
            else begin
              vld_p1     <= 1'b1;
              ev_p1.ext  <= 1'b0;
              ev_p1.brk  <= 1'b0;
              ev_p1.code <= rx_byte;
            end
          end
          EXT: begin
            if (rx_byte == PS2_EXT) begin
              dec_err_frame <= 1'b1;
              state         <= IDLE;
            end else if (rx_byte == PS2_BRK) begin
              state <= EXT_BRK;
            end else begin
              vld_p1     <= 1'b1;
              ev_p1.ext  <= 1'b1;
              ev_p1.brk  <= 1'b0;
              ev_p1.code <= rx_byte;
              state      <= IDLE;
            end
          end
          BRK, EXT_BRK: begin
            if (rx_byte == PS2_EXT || rx_byte == PS2_BRK) begin
              dec_err_frame <= 1'b1;
            end else begin
              vld_p1     <= 1'b1;
              ev_p1.ext  <= (state == EXT_BRK);
              ev_p1.brk  <= 1'b1;
              ev_p1.code <= rx_byte;
            end
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign err_frame = rx_err_frame | dec_err_frame;

  // Held-key tracking follows every decoded event, even one the FIFO drops.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      held      <= 1'b0;
      held_code <= '0;
    end else if (vld_p1) begin
      if (!ev_p1.brk) begin
        held      <= 1'b1;
        held_code <= {ev_p1.ext, ev_p1.code};
      end else if ({ev_p1.ext, ev_p1.code} == held_code) begin
        held <= 1'b0;
      end
    end
  end

  // ---- event queue stage ----
  logic [PS2_EVENT_W-1:0] head;
  ps2_event_t             head_ev;
  logic                   fifo_ne;
  logic                   pop;

  assign pop = fifo_ne & ev.ev_ready;

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PS2_EVENT_W)
  ) u_fifo (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .push      (vld_p1),
    .push_data (ev_p1),
    .pop       (pop),
    .head      (head),
    .not_empty (fifo_ne),
    .overflow  (err_overflow)
  );

  assign head_ev     = ps2_event_t'(head);
  assign ev.ev_valid = fifo_ne;
  assign ev.ev_code  = head_ev.code;
  assign ev.ev_ext   = head_ev.ext;
  assign ev.ev_brk   = head_ev.brk;
  assign ev.ev_ascii = scan_to_ascii(head_ev.ext, head_ev.code);

endmodule

// File: tb/tb_ps2_key_rx.sv
// Bench for ps2_key_rx: table of key sequences, hand-written corner cases and
// random keystrokes checked against a keystroke-level reference model.
module tb_ps2_key_rx;

  localparam int FIFO_DEPTH  = 4;
  localparam int TIMEOUT_CYC = 300;
  localparam int FILTER_LEN  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_clk = 1'b1;
  logic       key_data = 1'b1;
  logic       held;
  logic [8:0] held_code;
  logic       err_parity, err_frame, err_timeout, err_overflow;
  logic       rand_mode = 1'b0;
  logic       ready_force = 1'b1;
  logic       rnd_bit = 1'b1;

  ps2_key_rx_if bus();

  assign bus.ev_ready = rand_mode ? rnd_bit : ready_force;

  ps2_key_rx #(
    .FIFO_DEPTH  (FIFO_DEPTH),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .FILTER_LEN  (FILTER_LEN)
  ) dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .key_clk      (key_clk),
    .key_data     (key_data),
    .ev           (bus),
    .held         (held),
    .held_code    (held_code),
    .err_parity   (err_parity),
    .err_frame    (err_frame),
    .err_timeout  (err_timeout),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
  } ev_rec_t;

  typedef struct {
    int         n;
    logic [7:0] b0, b1, b2;
    logic [7:0] code;
    logic       ext, brk;
    logic [7:0] ascii;
    logic       held;
    logic [8:0] hcode;
  } vec_t;

  ev_rec_t got[$];
  int n_par = 0, n_frm = 0, n_to = 0, n_ovf = 0;
  int checks = 0, errors = 0;

  logic [7:0] letter_code [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

  // Random ready changes just after the active edge so the monitor sees the value used.
  initial forever begin
    @(posedge clk);
    #1 rnd_bit = 1'($urandom_range(0, 1));
  end

  // Monitor: record every handshake and count error pulse cycles.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.ev_valid && bus.ev_ready) got.push_back('{bus.ev_code, bus.ev_ext, bus.ev_brk, bus.ev_ascii});
      if (err_parity)   n_par++;
      if (err_frame)    n_frm++;
      if (err_timeout)  n_to++;
      if (err_overflow) n_ovf++;
    end
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "time limit");
  end

  function automatic logic [7:0] ref_ascii(input logic ext, input logic [7:0] code);
    for (int i = 0; i < 26; i++)
      if (!ext && letter_code[i] == code) return 8'(8'h41 + i);
    return 8'h00;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    key_data = b;
    repeat (5) @(negedge clk);
    key_clk = 1'b0;
    repeat (10) @(negedge clk);
    key_clk = 1'b1;
    if (glitch) begin
      repeat (3) @(negedge clk);
      key_clk = 1'b0;
      repeat (2) @(negedge clk);
      key_clk = 1'b1;
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par = 1'b0,
                           input bit bad_stop = 1'b0, input int glitch_at = -1);
    logic p;
    p = (~^b) ^ bad_par;
    ps2_bit(1'b0, glitch_at == 0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch_at == i + 1);
    ps2_bit(p, glitch_at == 9);
    ps2_bit(~bad_stop, glitch_at == 10);
    key_data = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic send_partial(input int nbits);
    logic [7:0] pat;
    pat = 8'hA5;
    ps2_bit(1'b0, 1'b0);
    for (int i = 1; i < nbits; i++) ps2_bit(pat[i], 1'b0);
    key_data = 1'b1;
  endtask

  task automatic expect_ev(input string name, input logic [7:0] code, input logic ext,
                           input logic brk, input logic [7:0] ascii);
    ev_rec_t e;
    for (int i = 0; i < 4000 && got.size() == 0; i++) @(negedge clk);
    check({name, " arrived"}, 32'(got.size() != 0), 32'(1));
    if (got.size() != 0) begin
      e = got.pop_front();
      check({name, " code"},  32'(e.code),  32'(code));
      check({name, " ext"},   32'(e.ext),   32'(ext));
      check({name, " brk"},   32'(e.brk),   32'(brk));
      check({name, " ascii"}, 32'(e.ascii), 32'(ascii));
    end
  endtask

  task automatic expect_none(input string name);
    repeat (40) @(negedge clk);
    check(name, 32'(got.size()), 32'(0));
  endtask

  initial begin
    vec_t       vt[7];
    logic [7:0] bs[3];
    int         p0, f0, t0, o0;
    logic       h, rx, rb;
    logic [8:0] hc;
    logic [7:0] rc;

    vt[0] = '{1, 8'h1C, 8'h00, 8'h00, 8'h1C, 1'b0, 1'b0, 8'h41, 1'b1, 9'h01C};
    vt[1] = '{2, 8'hF0, 8'h1C, 8'h00, 8'h1C, 1'b0, 1'b1, 8'h41, 1'b0, 9'h01C};
    vt[2] = '{2, 8'hE0, 8'h75, 8'h00, 8'h75, 1'b1, 1'b0, 8'h00, 1'b1, 9'h175};
    vt[3] = '{3, 8'hE0, 8'hF0, 8'h75, 8'h75, 1'b1, 1'b1, 8'h00, 1'b0, 9'h175};
    vt[4] = '{1, 8'h1D, 8'h00, 8'h00, 8'h1D, 1'b0, 1'b0, 8'h57, 1'b1, 9'h01D};
    vt[5] = '{2, 8'hE0, 8'h1C, 8'h00, 8'h1C, 1'b1, 1'b0, 8'h00, 1'b1, 9'h11C};
    vt[6] = '{2, 8'hF0, 8'h1D, 8'h00, 8'h1D, 1'b0, 1'b1, 8'h57, 1'b1, 9'h11C};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset ev_valid", 32'(bus.ev_valid), 32'(0));
    check("reset ev_code", 32'(bus.ev_code), 32'(0));
    check("reset ev_ext", 32'(bus.ev_ext), 32'(0));
    check("reset ev_brk", 32'(bus.ev_brk), 32'(0));
    check("reset ev_ascii", 32'(bus.ev_ascii), 32'(0));
    check("reset held", 32'(held), 32'(0));
    check("reset held_code", 32'(held_code), 32'(0));
    check("reset err pulses", 32'({err_parity, err_frame, err_timeout, err_overflow}), 32'(0));
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Table-driven key sequences
    p0 = n_par; f0 = n_frm; t0 = n_to; o0 = n_ovf;
    for (int v = 0; v < 7; v++) begin
      bs[0] = vt[v].b0; bs[1] = vt[v].b1; bs[2] = vt[v].b2;
      for (int k = 0; k < vt[v].n; k++) send_byte(bs[k]);
      expect_ev($sformatf("vec%0d", v), vt[v].code, vt[v].ext, vt[v].brk, vt[v].ascii);
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d held", v), 32'(held), 32'(vt[v].held));
      check($sformatf("vec%0d held_code", v), 32'(held_code), 32'(vt[v].hcode));
    end
    check("table no errors", 32'((n_par - p0) + (n_frm - f0) + (n_to - t0) + (n_ovf - o0)), 32'(0));

    // Parity error drops the byte and leaves the decoder idle
    p0 = n_par;
    send_byte(8'h1C, 1'b1);
    expect_none("parity no event");
    check("parity pulse", 32'(n_par - p0), 32'(1));
    send_byte(8'h1C);
    expect_ev("after parity", 8'h1C, 1'b0, 1'b0, 8'h41);

    // Stop bit error, then both wrong (parity wins)
    p0 = n_par; f0 = n_frm;
    send_byte(8'h1C, 1'b0, 1'b1);
    expect_none("stop no event");
    check("stop frame pulse", 32'(n_frm - f0), 32'(1));
    send_byte(8'h1C, 1'b1, 1'b1);
    expect_none("both no event");
    check("both parity pulse", 32'(n_par - p0), 32'(1));
    check("both no frame pulse", 32'(n_frm - f0), 32'(1));

    // Illegal prefix sequences
    f0 = n_frm;
    send_byte(8'hE0); send_byte(8'hE0);
    expect_none("E0E0 no event");
    send_byte(8'hF0); send_byte(8'hF0);
    expect_none("F0F0 no event");
    check("prefix frame pulses", 32'(n_frm - f0), 32'(2));
    send_byte(8'h1C);
    expect_ev("after bad prefix", 8'h1C, 1'b0, 1'b0, 8'h41);

    // Timeout of a partial frame also clears a pending E0
    t0 = n_to;
    send_byte(8'hE0);
    send_partial(4);
    repeat (TIMEOUT_CYC + 50) @(negedge clk);
    check("timeout pulse", 32'(n_to - t0), 32'(1));
    expect_none("timeout no event");
    send_byte(8'h1D);
    expect_ev("after timeout", 8'h1D, 1'b0, 1'b0, 8'h57);

    // Short glitch on key_clk mid-frame
    p0 = n_par; f0 = n_frm;
    send_byte(8'h1C, 1'b0, 1'b0, 4);
    expect_ev("glitch", 8'h1C, 1'b0, 1'b0, 8'h41);
    check("glitch no errors", 32'((n_par - p0) + (n_frm - f0)), 32'(0));

    // FIFO overflow with back-pressure
    @(posedge clk); #1 ready_force = 1'b0;
    o0 = n_ovf;
    send_byte(8'h15); send_byte(8'h1D); send_byte(8'h24); send_byte(8'h2D); send_byte(8'h2C);
    repeat (20) @(negedge clk);
    check("overflow pulse", 32'(n_ovf - o0), 32'(1));
    check("overflow nothing popped", 32'(got.size()), 32'(0));
    check("stalled ev_valid", 32'(bus.ev_valid), 32'(1));
    check("stalled head code", 32'(bus.ev_code), 32'(8'h15));
    check("stalled head ascii", 32'(bus.ev_ascii), 32'(8'h51));
    check("overflow held", 32'(held), 32'(1));
    check("overflow held_code", 32'(held_code), 32'(9'h02C));
    @(posedge clk); #1 ready_force = 1'b1;
    expect_ev("pop0", 8'h15, 1'b0, 1'b0, 8'h51);
    expect_ev("pop1", 8'h1D, 1'b0, 1'b0, 8'h57);
    expect_ev("pop2", 8'h24, 1'b0, 1'b0, 8'h45);
    expect_ev("pop3", 8'h2D, 1'b0, 1'b0, 8'h52);
    repeat (5) @(negedge clk);
    check("drained ev_valid", 32'(bus.ev_valid), 32'(0));
    check("drained no extra", 32'(got.size()), 32'(0));

    // Reset in the middle of a frame
    send_partial(5);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midreset held", 32'(held), 32'(0));
    check("midreset ev_valid", 32'(bus.ev_valid), 32'(0));
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    got.delete();
    send_byte(8'h1C);
    expect_ev("after midreset", 8'h1C, 1'b0, 1'b0, 8'h41);

    // Random keystrokes with random back-pressure
    h = 1'b1; hc = 9'h01C;
    p0 = n_par; f0 = n_frm; t0 = n_to; o0 = n_ovf;
    @(posedge clk); #1 rand_mode = 1'b1;
    for (int r = 0; r < 25; r++) begin
      if ($urandom_range(0, 1) == 1) rc = letter_code[$urandom_range(0, 25)];
      else rc = 8'($urandom_range(1, 127));
      rx = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      if (rx) send_byte(8'hE0);
      if (rb) send_byte(8'hF0);
      send_byte(rc);
      if (!rb) begin h = 1'b1; hc = {rx, rc}; end
      else if ({rx, rc} == hc) h = 1'b0;
      expect_ev($sformatf("rand%0d", r), rc, rx, rb, ref_ascii(rx, rc));
      check($sformatf("rand%0d held", r), 32'(held), 32'(h));
      check($sformatf("rand%0d held_code", r), 32'(held_code), 32'(hc));
    end
    check("random no errors", 32'((n_par - p0) + (n_frm - f0) + (n_to - t0) + (n_ovf - o0)), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
